// File: rtl/csr_timer_regfile_if.sv
// CSR-file bus: WB-stage CSR read/write, interrupt lines, exception/ertn commit and entry outputs.
// wb_vaddr exists only when CSR_BADV_EN is defined.
interface csr_timer_regfile_if #(
  parameter int unsigned HWI_NUM = 8
);
  logic               csr_re;
  logic [13:0]        csr_rnum;
  logic [31:0]        csr_rvalue;
  logic               csr_we;
  logic [31:0]        csr_wmask;
  logic [13:0]        csr_wnum;
  logic [31:0]        csr_wvalue;
  logic [HWI_NUM-1:0] hw_int_in;
  logic               ipi_int_in;
  logic               wb_ex;
  logic [5:0]         wb_ecode;
  logic [8:0]         wb_esubcode;
  logic [31:0]        wb_pc;
`ifdef CSR_BADV_EN
  logic [31:0]        wb_vaddr;
`endif
  logic               ertn_flush;
  logic               has_int;
  logic [31:0]        ex_entry;
  logic [31:0]        ertn_entry;

`ifdef CSR_BADV_EN
  modport master (
    output csr_re, csr_rnum, csr_we, csr_wmask, csr_wnum, csr_wvalue,
           hw_int_in, ipi_int_in, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  csr_rvalue, has_int, ex_entry, ertn_entry
  );
  modport slave (
    input  csr_re, csr_rnum, csr_we, csr_wmask, csr_wnum, csr_wvalue,
           hw_int_in, ipi_int_in, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output csr_rvalue, has_int, ex_entry, ertn_entry
  );
`else
  modport master (
    output csr_re, csr_rnum, csr_we, csr_wmask, csr_wnum, csr_wvalue,
           hw_int_in, ipi_int_in, wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
    input  csr_rvalue, has_int, ex_entry, ertn_entry
  );
  modport slave (
    input  csr_re, csr_rnum, csr_we, csr_wmask, csr_wnum, csr_wvalue,
           hw_int_in, ipi_int_in, wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
    output csr_rvalue, has_int, ex_entry, ertn_entry
  );
`endif
endinterface

// File: rtl/csr_timer_regfile.sv
// LA32 CSR file with constant timer and interrupt-pending logic.
// Optional BADV register (0x7) and wb_vaddr port are enabled by defining CSR_BADV_EN.
module csr_timer_regfile #(
  parameter int unsigned NUM_SAVE = 4,
  parameter int unsigned TIMER_W  = 32,
  parameter int unsigned HWI_NUM  = 8,
  parameter logic [31:0] TID_INIT = '0
) (
  input logic                clk,
  input logic                rst,
  csr_timer_regfile_if.slave bus
);
  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0c;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  logic [8:0]         r_crmd;
  logic [2:0]         r_prmd;
  logic [12:0]        r_lie;
  logic [1:0]         r_is_sw;
  logic [HWI_NUM-1:0] r_is_hw;
  logic               r_is_ti;
  logic               r_is_ipi;
  logic [5:0]         r_ecode;
  logic [8:0]         r_esubcode;
  logic [31:0]        r_era;
  logic [25:0]        r_eentry;
  logic [31:0]        r_save [NUM_SAVE];
  logic [31:0]        r_tid;
  logic [TIMER_W-1:0] r_tcfg;
  logic [TIMER_W-1:0] r_tval;
`ifdef CSR_BADV_EN
  logic [31:0]        r_badv;
`endif

  logic [31:0]        w_wv;
  logic [31:0]        w_keep;
  logic [12:0]        w_is;
  logic [31:0]        w_rdata;
  logic [TIMER_W-1:0] w_tcfg_new;
  logic               w_we_tcfg;
  logic               w_ticlr;
  logic               w_expire;

  assign w_wv       = bus.csr_wvalue & bus.csr_wmask;
  assign w_keep     = ~bus.csr_wmask;
  assign w_is       = {r_is_ipi, r_is_ti, 1'b0, 8'(r_is_hw), r_is_sw};
  assign w_we_tcfg  = bus.csr_we & (bus.csr_wnum == CSR_TCFG);
  assign w_ticlr    = bus.csr_we & (bus.csr_wnum == CSR_TICLR) & w_wv[0];
  assign w_tcfg_new = w_wv[TIMER_W-1:0] | (r_tcfg & w_keep[TIMER_W-1:0]);
  // A TCFG load pre-empts the count, including the expiry check on that edge.
  assign w_expire   = r_tcfg[0] & (r_tval == '0) & ~w_we_tcfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crmd     <= 9'h008;
      r_prmd     <= '0;
      r_era      <= '0;
      r_ecode    <= '0;
      r_esubcode <= '0;
    end else if (bus.wb_ex) begin
      r_prmd      <= r_crmd[2:0];
      r_crmd[2:0] <= '0;
      r_era       <= bus.wb_pc;
      r_ecode     <= bus.wb_ecode;
      r_esubcode  <= bus.wb_esubcode;
    end else if (bus.ertn_flush) begin
      r_crmd[2:0] <= r_prmd;
    end else if (bus.csr_we) begin
      if (bus.csr_wnum == CSR_CRMD) r_crmd <= w_wv[8:0] | (r_crmd & w_keep[8:0]);
      if (bus.csr_wnum == CSR_PRMD) r_prmd <= w_wv[2:0] | (r_prmd & w_keep[2:0]);
      if (bus.csr_wnum == CSR_ERA)  r_era  <= w_wv | (r_era & w_keep);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lie    <= '0;
      r_is_sw  <= '0;
      r_eentry <= '0;
      r_tid    <= TID_INIT;
      for (int unsigned i = 0; i < NUM_SAVE; i++) r_save[i] <= '0;
    end else if (bus.csr_we) begin
      if (bus.csr_wnum == CSR_ECFG)   r_lie    <= (w_wv[12:0] | (r_lie & w_keep[12:0])) & 13'h1bff;
      if (bus.csr_wnum == CSR_ESTAT)  r_is_sw  <= w_wv[1:0] | (r_is_sw & w_keep[1:0]);
      if (bus.csr_wnum == CSR_EENTRY) r_eentry <= w_wv[31:6] | (r_eentry & w_keep[31:6]);
      if (bus.csr_wnum == CSR_TID)    r_tid    <= w_wv | (r_tid & w_keep);
      for (int unsigned i = 0; i < NUM_SAVE; i++)
        if (bus.csr_wnum == 14'(CSR_SAVE0 + i)) r_save[i] <= w_wv | (r_save[i] & w_keep);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcfg   <= '0;
      r_tval   <= '0;
      r_is_ti  <= 1'b0;
      r_is_hw  <= '0;
      r_is_ipi <= 1'b0;
    end else begin
      r_is_hw  <= bus.hw_int_in;
      r_is_ipi <= bus.ipi_int_in;
      if (w_expire)     r_is_ti <= 1'b1;
      else if (w_ticlr) r_is_ti <= 1'b0;
      if (w_we_tcfg) begin
        r_tcfg <= w_tcfg_new;
        r_tval <= {w_tcfg_new[TIMER_W-1:2], 2'b00};
      end else if (r_tcfg[0]) begin
        // One-shot expiry parks TVAL at all-ones; a loaded value never has both low bits set.
        if (r_tval == '0)                     r_tval <= r_tcfg[1] ? {r_tcfg[TIMER_W-1:2], 2'b00} : '1;
        else if (r_tcfg[1] || r_tval != '1)   r_tval <= r_tval - TIMER_W'(1);
      end
    end
  end

`ifdef CSR_BADV_EN
  always_ff @(posedge clk) begin
    if (rst) r_badv <= '0;
    else if (bus.wb_ex) begin
      if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) r_badv <= bus.wb_vaddr;
    end else if (bus.csr_we && bus.csr_wnum == CSR_BADV) r_badv <= w_wv | (r_badv & w_keep);
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.csr_rnum)
      CSR_CRMD:   w_rdata = 32'(r_crmd);
      CSR_PRMD:   w_rdata = 32'(r_prmd);
      CSR_ECFG:   w_rdata = 32'(r_lie);
      CSR_ESTAT:  w_rdata = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};
      CSR_ERA:    w_rdata = r_era;
`ifdef CSR_BADV_EN
      CSR_BADV:   w_rdata = r_badv;
`endif
      CSR_EENTRY: w_rdata = {r_eentry, 6'b0};
      CSR_TID:    w_rdata = r_tid;
      CSR_TCFG:   w_rdata = 32'(r_tcfg);
      CSR_TVAL:   w_rdata = 32'(r_tval);
      default: begin
        for (int unsigned i = 0; i < NUM_SAVE; i++)
          if (bus.csr_rnum == 14'(CSR_SAVE0 + i)) w_rdata = r_save[i];
      end
    endcase
    if (!bus.csr_re) w_rdata = '0;
  end

  assign bus.csr_rvalue = w_rdata;
  assign bus.has_int    = r_crmd[2] & |(w_is & r_lie);
  assign bus.ex_entry   = {r_eentry, 6'b0};
  assign bus.ertn_entry = r_era;
endmodule

// File: tb/tb_csr_timer_regfile.sv
// Self-checking bench for csr_timer_regfile: vector table, directed timer/exception sequences,
// and randomized traffic against a per-CSR-number array model.
module tb_csr_timer_regfile;
  localparam int unsigned NUM_SAVE = 4;
  localparam int unsigned TIMER_W  = 32;
  localparam int unsigned HWI_NUM  = 8;
  localparam logic [31:0] TID_INIT = 32'h0;
  localparam logic [31:0] TMASK    = 32'hffff_ffff >> (32 - TIMER_W);
`ifdef CSR_BADV_EN
  localparam logic [31:0] BADV_ALL = 32'hffff_ffff;
`else
  localparam logic [31:0] BADV_ALL = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_timer_regfile_if #(.HWI_NUM(HWI_NUM)) bus ();

  csr_timer_regfile #(
    .NUM_SAVE(NUM_SAVE), .TIMER_W(TIMER_W), .HWI_NUM(HWI_NUM), .TID_INIT(TID_INIT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: one word per CSR number, holding only the bits that exist.
  logic [31:0] m_csr [0:127];

  function automatic logic [31:0] wr_mask(input logic [13:0] n);
    if (n >= 14'h30 && n < 14'(32'h30 + NUM_SAVE)) return 32'hffff_ffff;
    case (n)
      14'h00: return 32'h0000_01ff;
      14'h01: return 32'h0000_0007;
      14'h04: return 32'h0000_1bff;
      14'h05: return 32'h0000_0003;
      14'h06: return 32'hffff_ffff;
      14'h07: return BADV_ALL;
      14'h0c: return 32'hffff_ffc0;
      14'h40: return 32'hffff_ffff;
      14'h41: return TMASK;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] n);
    if (n >= 14'd128) return 32'h0;
    if (n == 14'h42) return m_csr[7'h42];
    if (wr_mask(n) == 32'h0) return 32'h0;
    return m_csr[n[6:0]];
  endfunction

  function automatic logic m_has_int();
    return m_csr[0][2] & (|(m_csr[5][12:0] & m_csr[4][12:0]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_csr[i] = 32'h0;
    m_csr[0]     = 32'h8;
    m_csr[7'h40] = TID_INIT;
  endtask

  task automatic model_step();
    logic [31:0] nx [0:127];
    logic [31:0] wm, tcfg, tv;
    logic [7:0]  hw8;
    logic        tcfg_wr, fire, clr, blocked;
    int          n;
    nx = m_csr;
    tcfg_wr = 1'b0; fire = 1'b0; clr = 1'b0;
    if (bus.csr_we && bus.csr_wnum < 14'd128) begin
      n  = int'(bus.csr_wnum);
      wm = wr_mask(bus.csr_wnum) & bus.csr_wmask;
      blocked = ((bus.wb_ex || bus.ertn_flush) && (n == 0 || n == 1 || n == 6)) || (bus.wb_ex && n == 7);
      if (!blocked) nx[n] = (m_csr[n] & ~wm) | (bus.csr_wvalue & wm);
      if (n == 'h41) begin
        tcfg_wr = 1'b1;
        nx['h42] = nx['h41] & ~32'h3;
      end
      if (n == 'h44 && bus.csr_wmask[0] && bus.csr_wvalue[0]) clr = 1'b1;
    end
    tcfg = m_csr['h41];
    tv   = m_csr['h42];
    if (!tcfg_wr && tcfg[0]) begin
      if (tv == 32'h0) begin
        fire = 1'b1;
        nx['h42] = tcfg[1] ? (tcfg & ~32'h3) : TMASK;
      end else if (tcfg[1] || tv != TMASK) nx['h42] = tv - 32'h1;
    end
    hw8 = 8'(bus.hw_int_in);
    nx[5][12:2] = {bus.ipi_int_in, fire ? 1'b1 : (clr ? 1'b0 : m_csr[5][11]), 1'b0, hw8};
    if (bus.wb_ex) begin
      nx[1] = m_csr[0] & 32'h7;
      nx[0] = m_csr[0] & ~32'h7;
      nx[6] = bus.wb_pc;
      nx[5][21:16] = bus.wb_ecode;
      nx[5][30:22] = bus.wb_esubcode;
`ifdef CSR_BADV_EN
      if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) nx[7] = bus.wb_vaddr;
`endif
    end else if (bus.ertn_flush) begin
      nx[0] = (m_csr[0] & ~32'h7) | (m_csr[1] & 32'h7);
    end
    m_csr = nx;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle();
    bus.csr_re = 1'b0; bus.csr_rnum = '0; bus.csr_we = 1'b0; bus.csr_wmask = '0;
    bus.csr_wnum = '0; bus.csr_wvalue = '0; bus.hw_int_in = '0; bus.ipi_int_in = 1'b0;
    bus.wb_ex = 1'b0; bus.wb_ecode = '0; bus.wb_esubcode = '0; bus.wb_pc = '0;
    bus.ertn_flush = 1'b0;
`ifdef CSR_BADV_EN
    bus.wb_vaddr = '0;
`endif
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
    bus.csr_we = 1'b1; bus.csr_wnum = n; bus.csr_wvalue = v; bus.csr_wmask = m;
    cyc();
    bus.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] v);
    bus.csr_re = 1'b1; bus.csr_rnum = n;
    #1;
    v = bus.csr_rvalue;
    bus.csr_re = 1'b0;
  endtask

  typedef struct {
    logic [13:0] num;
    logic [31:0] val;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [15];
  logic [13:0] nums [16];

  initial begin
    logic [31:0] v, tv;
    int          k;
    bit          ti_seen, tv_moved;
    total = 0; bad = 0;
    tbl[0]  = '{14'h30, 32'h1234_5678, 32'hffff_ffff, 32'h1234_5678};
    tbl[1]  = '{14'h30, 32'haaaa_5555, 32'hffff_0000, 32'haaaa_5678};
    tbl[2]  = '{14'h34, 32'hdead_beef, 32'hffff_ffff, 32'h0};
    tbl[3]  = '{14'h33, 32'h0bad_f00d, 32'hffff_ffff, 32'h0bad_f00d};
    tbl[4]  = '{14'h04, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_1bff};
    tbl[5]  = '{14'h04, 32'h0,         32'hffff_ffff, 32'h0};
    tbl[6]  = '{14'h05, 32'hffff_ffff, 32'hffff_ffff, 32'h3};
    tbl[7]  = '{14'h05, 32'h0,         32'hffff_ffff, 32'h0};
    tbl[8]  = '{14'h00, 32'h0000_01ff, 32'h0,         32'h8};
    tbl[9]  = '{14'h01, 32'hffff_ffff, 32'hffff_ffff, 32'h7};
    tbl[10] = '{14'h01, 32'h0,         32'hffff_ffff, 32'h0};
    tbl[11] = '{14'h40, 32'hcafe_f00d, 32'hffff_0000, 32'hcafe_0000 | (TID_INIT & 32'h0000_ffff)};
    tbl[12] = '{14'h0c, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffc0};
    tbl[13] = '{14'h02, 32'hffff_ffff, 32'hffff_ffff, 32'h0};
    tbl[14] = '{14'h07, 32'hffff_ffff, 32'hffff_ffff, BADV_ALL};
    nums = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0c, 14'h30,
             14'h31, 14'h33, 14'h34, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02};

    idle();
    rst = 1'b1;
    model_reset();
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    rd(14'h00, v); check("reset_crmd", v, 32'h8);
    rd(14'h40, v); check("reset_tid", v, TID_INIT);
    rd(14'h42, v); check("reset_tval", v, 32'h0);
    check("reset_has_int", 32'(bus.has_int), 32'h0);
    check("reset_ex_entry", bus.ex_entry, 32'h0);
    check("reset_ertn_entry", bus.ertn_entry, 32'h0);
    bus.csr_re = 1'b0; bus.csr_rnum = 14'h00; #1;
    check("rvalue_no_re", bus.csr_rvalue, 32'h0);

    for (int i = 0; i < 15; i++) begin
      wr(tbl[i].num, tbl[i].val, tbl[i].mask);
      rd(tbl[i].num, v);
      check($sformatf("vec%0d_csr%0h", i, tbl[i].num), v, tbl[i].exp);
    end

    // Read during the write cycle sees the old value.
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h31; bus.csr_wvalue = 32'h5a5a_5a5a; bus.csr_wmask = '1;
    bus.csr_re = 1'b1; bus.csr_rnum = 14'h31; #1;
    check("read_in_write_cycle", bus.csr_rvalue, 32'h0);
    cyc();
    bus.csr_we = 1'b0;
    rd(14'h31, v); check("read_after_write", v, 32'h5a5a_5a5a);

    // Exception commit and ertn
    wr(14'h0c, 32'h1c00_8000, '1);
    wr(14'h00, 32'h7, '1);
    bus.wb_ex = 1'b1; bus.wb_pc = 32'h1c00_0100; bus.wb_ecode = 6'h0b; bus.wb_esubcode = 9'h0;
    cyc();
    bus.wb_ex = 1'b0;
    rd(14'h06, v); check("ex_era", v, 32'h1c00_0100);
    check("ex_entry", bus.ex_entry, 32'h1c00_8000);
    check("ex_ertn_entry", bus.ertn_entry, 32'h1c00_0100);
    rd(14'h05, v); check("ex_estat_ecode", (v >> 16) & 32'h3f, 32'h0b);
    rd(14'h01, v); check("ex_prmd", v, 32'h7);
    rd(14'h00, v); check("ex_crmd", v, 32'h0);
    bus.ertn_flush = 1'b1;
    cyc();
    bus.ertn_flush = 1'b0;
    rd(14'h00, v); check("ertn_crmd", v, 32'h7);

    // wb_ex, ertn_flush and a CRMD write together: only the exception takes effect.
    bus.wb_ex = 1'b1; bus.ertn_flush = 1'b1; bus.wb_pc = 32'h1c00_0200;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h00; bus.csr_wvalue = 32'h1ff; bus.csr_wmask = '1;
    cyc();
    idle();
    rd(14'h00, v); check("prio_crmd", v, 32'h0);
    rd(14'h01, v); check("prio_prmd", v, 32'h7);
    rd(14'h06, v); check("prio_era", v, 32'h1c00_0200);
    bus.ertn_flush = 1'b1;
    cyc();
    bus.ertn_flush = 1'b0;
    rd(14'h00, v); check("prio_ertn_crmd", v, 32'h7);

    // Periodic timer, InitVal=4
    wr(14'h41, 32'h13, '1);
    rd(14'h42, v); check("tval_loaded", v, 32'h10);
    k = -1;
    for (int c = 0; c <= 40; c++) begin
      rd(14'h05, v);
      if (v[11]) begin k = c; break; end
      cyc();
    end
    check("ti_first_latency", 32'(k), 32'd17);
    rd(14'h42, v); check("tval_reload", v, 32'h10);
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h05, v); check("ticlr_clears", 32'(v[11]), 32'h0);
    rd(14'h44, v); check("ticlr_reads_0", v, 32'h0);
    k = -1;
    for (int c = 1; c <= 40; c++) begin
      rd(14'h05, v);
      if (v[11]) begin k = c; break; end
      cyc();
    end
    check("ti_second_latency", 32'(k), 32'd17);
    wr(14'h41, 32'h0, '1);
    wr(14'h44, 32'h1, 32'h1);

    // One-shot timer, InitVal=2
    wr(14'h41, 32'h9, '1);
    k = -1;
    for (int c = 0; c <= 40; c++) begin
      rd(14'h05, v);
      if (v[11]) begin k = c; break; end
      cyc();
    end
    check("oneshot_latency", 32'(k), 32'd9);
    rd(14'h42, v); check("oneshot_tval_ones", v, TMASK);

    // Interrupt pending/enable (CRMD.IE=1 from ertn)
    wr(14'h04, 32'h800, '1);
    check("has_int_ti", 32'(bus.has_int), 32'h1);
    wr(14'h04, 32'h0, '1);
    check("has_int_lie0", 32'(bus.has_int), 32'h0);
    bus.hw_int_in = HWI_NUM'(1);
    wr(14'h04, 32'h4, '1);
    check("has_int_hw0", 32'(bus.has_int), 32'h1);
    bus.hw_int_in = '0;
    wr(14'h04, 32'h0, '1);

    wr(14'h44, 32'h1, 32'h1);
    ti_seen = 1'b0; tv_moved = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      rd(14'h05, v);
      rd(14'h42, tv);
      if (v[11]) ti_seen = 1'b1;
      if (tv != TMASK) tv_moved = 1'b1;
      cyc();
    end
    check("oneshot_no_refire", 32'(ti_seen), 32'h0);
    check("oneshot_tval_holds", 32'(tv_moved), 32'h0);

    // BADV capture on ALE
    bus.wb_ex = 1'b1; bus.wb_ecode = 6'h09; bus.wb_pc = 32'h1c00_0300;
`ifdef CSR_BADV_EN
    bus.wb_vaddr = 32'h1234;
    cyc();
    idle();
    rd(14'h07, v); check("badv_ale", v, 32'h1234);
`else
    cyc();
    idle();
    rd(14'h07, v); check("badv_absent", v, 32'h0);
`endif

    // Reset mid-count
    wr(14'h41, 32'h13, '1);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd(14'h42, v); check("rst_tval", v, 32'h0);
    rd(14'h41, v); check("rst_tcfg", v, 32'h0);
    rd(14'h05, v); check("rst_estat", v, 32'h0);
    repeat (5) cyc();
    rd(14'h42, v); check("rst_timer_stopped", v, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.csr_we     = ($urandom_range(0, 2) == 0);
      bus.csr_wnum   = nums[$urandom_range(0, 15)];
      bus.csr_wmask  = ($urandom_range(0, 1) == 1) ? 32'hffff_ffff : 32'($urandom);
      bus.csr_wvalue = 32'($urandom);
      if (bus.csr_wnum == 14'h41) bus.csr_wvalue = bus.csr_wvalue & 32'h3f;
      bus.csr_re     = ($urandom_range(0, 3) != 0);
      bus.csr_rnum   = nums[$urandom_range(0, 15)];
      bus.hw_int_in  = HWI_NUM'($urandom);
      bus.ipi_int_in = 1'($urandom_range(0, 1));
      bus.wb_ex      = ($urandom_range(0, 15) == 0);
      bus.ertn_flush = ($urandom_range(0, 15) == 0);
      bus.wb_ecode   = ($urandom_range(0, 1) == 1) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom);
      bus.wb_esubcode = 9'($urandom);
      bus.wb_pc      = 32'($urandom);
`ifdef CSR_BADV_EN
      bus.wb_vaddr   = 32'($urandom);
`endif
      #1;
      check("rand_rvalue", bus.csr_rvalue, bus.csr_re ? m_read(bus.csr_rnum) : 32'h0);
      check("rand_has_int", 32'(bus.has_int), 32'(m_has_int()));
      check("rand_ex_entry", bus.ex_entry, m_csr[12]);
      check("rand_ertn_entry", bus.ertn_entry, m_csr[6]);
      cyc();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
